manchester_encoder_100m: RTL and testbench
==========================================

Name: manchester_encoder_100m

Overview:
Serial Manchester (IEEE 802.3 polarity-inverted, G.E. Thomas) line encoder running in the 100 MHz clk_sys domain. It accepts one data bit per ready/valid handshake and drives it as a differential pair ddr_p/ddr_n. Each bit occupies 4 clocks (2 per half-bit), giving a sustained 25 Mbps line rate. It sits between the frame serializer and the output pad/ODDR stage of the coax link transmitter.

Parameters:
HALF_BIT_CYCLES, 2, clocks per Manchester half-bit; a bit lasts 2*HALF_BIT_CYCLES clocks; must be >= 1.

Ports:
clk_sys  input  1  system clock, 100 MHz; all logic on rising edge.
rst_n  input  1  synchronous reset, active-high (asserted = 1) despite the name; sampled on clk_sys rising edge.
tx_en  input  1  transmitter enable; 0 forces idle and blocks acceptance.
bit_in  input  1  data bit; sampled when bit_valid && bit_ready.
bit_valid  input  1  bit_in is valid.
bit_ready  output  1  encoder can accept a bit this cycle (combinational).
ddr_p  output  1  Manchester line, true polarity (registered).
ddr_n  output  1  always the exact complement of ddr_p (registered).

Behaviour:
- Reset (rst_n=1 at an edge): state=IDLE, phase=0, ddr_p=0, ddr_n=1. bit_ready is 0 while tx_en=0.
- Encoding: bit 1 -> ddr_p high for the first half, low for the second ("10"). Bit 0 -> "01". ddr_n = ~ddr_p in every cycle, including reset and idle.
- States:
  - IDLE: outputs hold idle level (p=0, n=1).
  - ACTIVE: phase counter runs 0..2*HALF_BIT_CYCLES-1.
- bit_ready = tx_en && (state==IDLE || phase==2*HALF_BIT_CYCLES-1). This allows gapless back-to-back bits.
- Accept: at the rising edge where bit_valid && bit_ready, latch bit_in, enter ACTIVE, set phase=0, and register ddr_p=bit_in (first half) at that same edge.
  - Latency from the accept edge to the first-half level on the pins is 0 clocks.
  - Levels visible after accept edge E: first half for E..E+1, second half (~bit) for E+2..E+3 (HALF_BIT_CYCLES=2).
- Phase advance: each edge in ACTIVE increments phase. When phase reaches HALF_BIT_CYCLES-1, the next edge drives ddr_p=~bit.
- End of bit: at the last phase, if a new bit is accepted, start it immediately (phase=0, new first half). Otherwise return to IDLE and drive the idle level.
- bit_valid without bit_ready: no effect. The source must hold bit_in/bit_valid until accepted.
- tx_en deasserted mid-bit: the next edge aborts the bit, goes to IDLE, and drives the idle level. No partial bit is resumed later.
- tx_en asserted from IDLE: bit_ready rises combinationally in the same cycle.
- Reset mid-bit: immediate return to the reset state at that edge. Reset has priority over everything else.
- Transitions: every bit has a mid-bit transition. Every 4-clock bit window therefore contains at least 1 edge on ddr_p.

Test Plan:
- Reset/enable: hold rst_n=1 for 20 clk, release with tx_en=0 -> bit_ready=0, ddr_p=0, ddr_n=1. Set tx_en=1 -> bit_ready=1 within 1 clk.
- Single bits: send 0,1,0,1, each with a 1-cycle valid pulse -> per bit, ddr_p reads 0,0,1,1 for "0" and 1,1,0,0 for "1" over the 4 edges after acceptance. ddr_n always equals ~ddr_p.
- Patterns: 10 alternating bits, 8 zeros, 8 ones, 20 random bits -> each bit matches its 2-clock/2-clock half pattern. No complement error in any cycle.
- Back-to-back throughput: hold bit_valid=1 with a new bit on every accept for 50 bits -> exactly 200 clk (2000 ns), i.e. 25 Mbps. No idle cycles between bits.
- Handshake: assert bit_valid=1, bit_in=1 while busy -> bit is accepted only on a cycle with bit_ready=1. bit_ready drops after acceptance and returns at the last phase or in IDLE.
- Abort: drop tx_en during the first half of a bit -> next edge gives ddr_p=0, ddr_n=1, bit_ready=0. Re-enable and send a bit -> clean encoding.

Source files
------------

// File: rtl/manchester_encoder_100m_if.sv
// Bit-stream handshake between the frame serializer and the Manchester encoder.
// The serializer holds bit_in/bit_valid until it sees bit_ready at a clock edge.
interface manchester_encoder_100m_if;
    logic bit_in;
    logic bit_valid;
    logic bit_ready;

    modport master (
        output bit_in,
        output bit_valid,
        input  bit_ready
    );

    modport slave (
        input  bit_in,
        input  bit_valid,
        output bit_ready
    );
endinterface

// File: rtl/manchester_encoder_100m.sv
// Manchester (G.E. Thomas polarity: 1 -> "10", 0 -> "01") line encoder for the coax link.
// One bit per handshake, 2*HALF_BIT_CYCLES clocks per bit, differential registered outputs.
module manchester_encoder_100m #(
    parameter int unsigned HALF_BIT_CYCLES = 2
) (
    input  logic                            clk_sys,
    input  logic                            rst_n,
    input  logic                            tx_en,
    manchester_encoder_100m_if.slave        bit_if,
    output logic                            ddr_p,
    output logic                            ddr_n
);

    localparam int unsigned BIT_CYCLES = 2 * HALF_BIT_CYCLES;
    localparam int unsigned PHASE_W    = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(BIT_CYCLES - 1);
    localparam logic [PHASE_W-1:0] PHASE_MID  = PHASE_W'(HALF_BIT_CYCLES - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic                 bit_q,   bit_d;
    logic                 ddr_p_q, ddr_p_d;
    logic                 ddr_n_q;

    logic                 last_phase_c;
    logic                 ready_c;
    logic                 accept_c;

    // Ready in IDLE or on the last phase so a new bit can follow with no gap.
    assign last_phase_c       = (state_q == ST_ACTIVE) && (phase_q == PHASE_LAST);
    assign ready_c            = tx_en && ((state_q == ST_IDLE) || last_phase_c);
    assign accept_c           = ready_c && bit_if.bit_valid;
    assign bit_if.bit_ready   = ready_c;

    always_ff @(posedge clk_sys) begin
        if (rst_n) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            bit_q   <= 1'b0;
            ddr_p_q <= 1'b0;
            ddr_n_q <= 1'b1;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            ddr_p_q <= ddr_p_d;
            ddr_n_q <= ~ddr_p_d;
        end
    end

    // Next state: disable aborts, accept starts a first half, mid-point flips the line.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        ddr_p_d = ddr_p_q;

        if (!tx_en) begin
            state_d = ST_IDLE;
            phase_d = '0;
            ddr_p_d = 1'b0;
        end else if (accept_c) begin
            state_d = ST_ACTIVE;
            phase_d = '0;
            bit_d   = bit_if.bit_in;
            ddr_p_d = bit_if.bit_in;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    phase_d = '0;
                    ddr_p_d = 1'b0;
                end
                ST_ACTIVE: begin
                    if (phase_q == PHASE_LAST) begin
                        state_d = ST_IDLE;
                        phase_d = '0;
                        ddr_p_d = 1'b0;
                    end else begin
                        phase_d = phase_q + PHASE_W'(1);
                        if (phase_q == PHASE_MID) begin
                            ddr_p_d = ~bit_q;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                    ddr_p_d = 1'b0;
                end
            endcase
        end
    end

    assign ddr_p = ddr_p_q;
    assign ddr_n = ddr_n_q;

endmodule

// File: tb/tb_manchester_encoder_100m.sv
// Directed bench for manchester_encoder_100m: reset, single bits, patterns,
// gapless throughput, handshake stalls, abort and mid-bit reset.
module tb_manchester_encoder_100m;

    logic clk_sys;
    logic rst_n;
    logic tx_en;
    logic ddr_p;
    logic ddr_n;

    int checks;
    int errors;

    manchester_encoder_100m_if bus ();

    manchester_encoder_100m #(.HALF_BIT_CYCLES(2)) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .tx_en   (tx_en),
        .bit_if  (bus),
        .ddr_p   (ddr_p),
        .ddr_n   (ddr_n)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b1;
        tx_en         = 1'b0;
        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (ddr_p !== 1'b0 || ddr_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_reset: p=%b n=%b required p=0 n=1", ddr_p, ddr_n);
        end
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.bit_ready !== 1'b0 || ddr_p !== 1'b0 || ddr_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: ready=%b p=%b n=%b required ready=0 p=0 n=1",
                     bus.bit_ready, ddr_p, ddr_n);
        end
        tx_en = 1'b1;
        #1;
        checks++;
        if (bus.bit_ready !== 1'b1) begin
            errors++;
            $display("FAIL enable_ready: ready=%b required 1", bus.bit_ready);
        end
    endtask

    task automatic test_single_bits();
        logic [3:0] seq;
        logic       b;
        logic       exp;
        seq = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            b = seq[i];
            bus.bit_in    = b;
            bus.bit_valid = 1'b1;
            #1;
            checks++;
            if (bus.bit_ready !== 1'b1) begin
                errors++;
                $display("FAIL single_ready bit%0d: ready=%b required 1", i, bus.bit_ready);
            end
            tick();
            bus.bit_valid = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (k > 0) tick();
                exp = (k < 2) ? b : ~b;
                checks++;
                if (ddr_p !== exp || ddr_n !== ~exp) begin
                    errors++;
                    $display("FAIL single bit%0d phase%0d: p=%b n=%b required p=%b n=%b",
                             i, k, ddr_p, ddr_n, exp, ~exp);
                end
            end
            tick();
            checks++;
            if (ddr_p !== 1'b0 || ddr_n !== 1'b1 || bus.bit_ready !== 1'b1) begin
                errors++;
                $display("FAIL single_idle bit%0d: p=%b n=%b ready=%b required p=0 n=1 ready=1",
                         i, ddr_p, ddr_n, bus.bit_ready);
            end
        end
    endtask

    task automatic test_patterns();
        logic [63:0] pat [4];
        int          len [4];
        logic        b;
        logic        exp;
        pat[0] = 64'h0000_0000_0000_02AA; len[0] = 10;
        pat[1] = 64'h0000_0000_0000_0000; len[1] = 8;
        pat[2] = 64'h0000_0000_0000_00FF; len[2] = 8;
        pat[3] = 64'(($urandom() & 32'h000F_FFFF));
        len[3] = 20;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < len[p]; i++) begin
                b = pat[p][i];
                bus.bit_in    = b;
                bus.bit_valid = 1'b1;
                #1;
                checks++;
                if (bus.bit_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL pattern%0d_ready bit%0d: ready=%b required 1", p, i, bus.bit_ready);
                end
                tick();
                for (int k = 0; k < 4; k++) begin
                    if (k > 0) tick();
                    exp = (k < 2) ? b : ~b;
                    checks++;
                    if (ddr_p !== exp || ddr_n !== ~exp) begin
                        errors++;
                        $display("FAIL pattern%0d bit%0d phase%0d: p=%b n=%b required p=%b n=%b",
                                 p, i, k, ddr_p, ddr_n, exp, ~exp);
                    end
                end
            end
            bus.bit_valid = 1'b0;
            tick();
            checks++;
            if (ddr_p !== 1'b0 || ddr_n !== 1'b1) begin
                errors++;
                $display("FAIL pattern%0d_idle: p=%b n=%b required p=0 n=1", p, ddr_p, ddr_n);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] pat;
        logic        b;
        logic        exp;
        time         t0;
        time         t1;
        pat = 64'hA5C3_0F96_3C5A_E7D1;
        t0  = 0;
        for (int i = 0; i < 50; i++) begin
            b = pat[i];
            bus.bit_in    = b;
            bus.bit_valid = 1'b1;
            #1;
            checks++;
            if (bus.bit_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready bit%0d: ready=%b required 1", i, bus.bit_ready);
            end
            tick();
            if (i == 0) t0 = $time;
            for (int k = 0; k < 4; k++) begin
                if (k > 0) tick();
                exp = (k < 2) ? b : ~b;
                checks++;
                if (ddr_p !== exp || ddr_n !== ~exp) begin
                    errors++;
                    $display("FAIL b2b bit%0d phase%0d: p=%b n=%b required p=%b n=%b",
                             i, k, ddr_p, ddr_n, exp, ~exp);
                end
            end
        end
        bus.bit_valid = 1'b0;
        tick();
        t1 = $time;
        checks++;
        if ((t1 - t0) != 64'd2000 || ddr_p !== 1'b0) begin
            errors++;
            $display("FAIL b2b_throughput: span=%0t p=%b required span=2000 p=0", t1 - t0, ddr_p);
        end
    endtask

    task automatic test_handshake();
        logic [3:0] exp_p;
        logic [3:0] exp_r;
        // Valid held with bit 1; bit_in flips to 0 while busy and must not disturb the bit.
        exp_p = 4'b0011;
        exp_r = 4'b1000;
        bus.bit_in    = 1'b1;
        bus.bit_valid = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            if (k == 1) bus.bit_in = 1'b0;
            #1;
            checks++;
            if (ddr_p !== exp_p[k] || ddr_n !== ~exp_p[k] || bus.bit_ready !== exp_r[k]) begin
                errors++;
                $display("FAIL handshake phase%0d: p=%b n=%b ready=%b required p=%b n=%b ready=%b",
                         k, ddr_p, ddr_n, bus.bit_ready, exp_p[k], ~exp_p[k], exp_r[k]);
            end
        end
        tick();
        bus.bit_valid = 1'b0;
        checks++;
        if (ddr_p !== 1'b0 || bus.bit_ready !== 1'b0) begin
            errors++;
            $display("FAIL handshake_second_accept: p=%b ready=%b required p=0 ready=0",
                     ddr_p, bus.bit_ready);
        end
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (ddr_p !== 1'b0 || ddr_n !== 1'b1 || bus.bit_ready !== 1'b1) begin
            errors++;
            $display("FAIL handshake_idle: p=%b n=%b ready=%b required p=0 n=1 ready=1",
                     ddr_p, ddr_n, bus.bit_ready);
        end
    endtask

    task automatic test_abort();
        logic exp;
        bus.bit_in    = 1'b1;
        bus.bit_valid = 1'b1;
        tick();
        bus.bit_valid = 1'b0;
        tx_en         = 1'b0;
        #1;
        checks++;
        if (ddr_p !== 1'b1 || bus.bit_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_first_half: p=%b ready=%b required p=1 ready=0", ddr_p, bus.bit_ready);
        end
        tick();
        checks++;
        if (ddr_p !== 1'b0 || ddr_n !== 1'b1 || bus.bit_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_edge: p=%b n=%b ready=%b required p=0 n=1 ready=0",
                     ddr_p, ddr_n, bus.bit_ready);
        end
        tick();
        tick();
        tx_en = 1'b1;
        #1;
        checks++;
        if (ddr_p !== 1'b0 || bus.bit_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_no_resume: p=%b ready=%b required p=0 ready=1", ddr_p, bus.bit_ready);
        end
        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b1;
        tick();
        bus.bit_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            exp = (k < 2) ? 1'b0 : 1'b1;
            checks++;
            if (ddr_p !== exp || ddr_n !== ~exp) begin
                errors++;
                $display("FAIL abort_resend phase%0d: p=%b n=%b required p=%b n=%b",
                         k, ddr_p, ddr_n, exp, ~exp);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_bit();
        bus.bit_in    = 1'b1;
        bus.bit_valid = 1'b1;
        tick();
        bus.bit_valid = 1'b0;
        rst_n         = 1'b1;
        tick();
        checks++;
        if (ddr_p !== 1'b0 || ddr_n !== 1'b1 || bus.bit_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_bit: p=%b n=%b ready=%b required p=0 n=1 ready=1",
                     ddr_p, ddr_n, bus.bit_ready);
        end
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (ddr_p !== 1'b0 || ddr_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_bit_after: p=%b n=%b required p=0 n=1", ddr_p, ddr_n);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_bits();
        test_patterns();
        test_back_to_back();
        test_handshake();
        test_abort();
        test_reset_mid_bit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "timeout");
    end

endmodule
